// File: rtl/act_pkg.sv
// Shared types and Q4.4 constants for the activation scheduler and its activation pipeline.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_RELU     = 2'b00,
    ACT_HSWISH   = 2'b01,
    ACT_HSIGMOID = 2'b10,
    ACT_BYPASS   = 2'b11
  } act_mode_e;

  // Raw Q4.4 integers: 3.0, 6.0, and the hswish divisor 6.0
  localparam int RELU6_OFFSET = 48;
  localparam int RELU6_MAX    = 96;
  localparam int HSWISH_DIV   = 96;
  localparam int HSIG_DIV     = 6;

  // Rescale a Q4.4 raw constant to a format with frac_bits fractional bits.
  function automatic int q_scale(input int q44, input int frac_bits);
    return (q44 << frac_bits) >>> 4;
  endfunction

endpackage

// File: rtl/act_unit.sv
// Two-stage activation pipeline: stage 1 forms relu6(x+3) and x*r, stage 2 divides,
// saturates and selects the mode result. The id/valid tag rides alongside.
module act_unit
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int ID_W       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid,
  input  logic signed [DATA_WIDTH-1:0] data,
  input  act_mode_e                    mode,
  input  logic [ID_W-1:0]              id,
  output logic [1:0]                   stage_valid,
  output logic signed [DATA_WIDTH-1:0] res_data,
  output logic [ID_W-1:0]              res_id
);

  localparam int PROD_W = 2 * DATA_WIDTH - 1;
  localparam logic signed [DATA_WIDTH:0]   OFFSET_W   = (DATA_WIDTH+1)'(q_scale(RELU6_OFFSET, FRAC_BITS));
  localparam logic signed [DATA_WIDTH:0]   MAX_W      = (DATA_WIDTH+1)'(q_scale(RELU6_MAX, FRAC_BITS));
  localparam logic signed [PROD_W-1:0]     DIV_W      = PROD_W'(q_scale(HSWISH_DIV, FRAC_BITS));
  localparam logic signed [PROD_W-1:0]     SAT_HI     = PROD_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PROD_W-1:0]     SAT_LO     = ~SAT_HI;
  localparam logic        [DATA_WIDTH-1:0] HSIG_DIV_W = DATA_WIDTH'(HSIG_DIV);

  logic signed [DATA_WIDTH:0]   shifted;
  logic signed [DATA_WIDTH-1:0] r_c;
  logic signed [PROD_W-1:0]     prod_c;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    shifted = $signed({data[DATA_WIDTH-1], data}) + OFFSET_W;
    r_c     = shifted[DATA_WIDTH-1:0];
    if (shifted[DATA_WIDTH]) r_c = '0;
    else if (shifted > MAX_W) r_c = MAX_W[DATA_WIDTH-1:0];
    prod_c = PROD_W'(data) * PROD_W'(r_c);
  end

  logic                         s1_valid, res_valid;
  logic signed [DATA_WIDTH-1:0] s1_x, s1_r;
  logic signed [PROD_W-1:0]     s1_prod;
  act_mode_e                    s1_mode;
  logic [ID_W-1:0]              s1_id;
  logic signed [PROD_W-1:0]     quot;
  logic signed [DATA_WIDTH-1:0] y_c;

  always_comb begin
    quot = s1_prod / DIV_W;  // signed divide truncates toward zero
    y_c  = s1_x;
    case (s1_mode)
      ACT_RELU:     y_c = s1_x[DATA_WIDTH-1] ? '0 : s1_x;
      ACT_HSWISH: begin
        if (quot > SAT_HI)      y_c = SAT_HI[DATA_WIDTH-1:0];
        else if (quot < SAT_LO) y_c = SAT_LO[DATA_WIDTH-1:0];
        else                    y_c = quot[DATA_WIDTH-1:0];
      end
      ACT_HSIGMOID: y_c = $unsigned(s1_r) / HSIG_DIV_W;
      default:      y_c = s1_x;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      s1_valid  <= valid;
      res_valid <= s1_valid;
    end
  end

  // Payload registers are qualified by the valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    s1_x     <= data;
    s1_r     <= r_c;
    s1_prod  <= prod_c;
    s1_mode  <= mode;
    s1_id    <= id;
    res_data <= y_c;
    res_id   <= s1_id;
  end

  assign stage_valid = {res_valid, s1_valid};

endmodule

// File: rtl/act_sched.sv
// Round-robin, credit-gated scheduler sharing one activation pipeline among NUM_REQ
// requesters; results return in issue order through an OUT_DEPTH-entry FIFO.
module act_sched
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int NUM_REQ    = 4,
  parameter int OUT_DEPTH  = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [2*NUM_REQ-1:0]          req_mode,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic signed [DATA_WIDTH-1:0]  rsp_data,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          busy
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [ID_W-1:0]              ptr, grant_id;
  logic                         grant_any, issue;
  logic [NUM_REQ-1:0]           rot;
  logic [ID_W:0]                sum;
  logic signed [DATA_WIDTH-1:0] sel_data, res_data;
  act_mode_e                    sel_mode;
  logic [ID_W-1:0]              res_id;
  logic [1:0]                   stage_valid;
  logic [CNT_W-1:0]             count;
  logic [CNT_W:0]               occ;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic                         push, pop;
  entry_t                       mem [OUT_DEPTH];
  entry_t                       head;

  // Rotate so bit k is requester ptr+k; the lowest set bit wins.
  always_comb begin
    rot       = NUM_REQ'({req_valid, req_valid} >> ptr);
    grant_any = 1'b0;
    grant_id  = '0;
    sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && rot[k]) begin
        grant_any = 1'b1;
        sum       = {1'b0, ptr} + (ID_W+1)'(k);
        grant_id  = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : sum[ID_W-1:0];
      end
    end
  end

  // Credits count only registered state, so a same-cycle pop frees nothing until next cycle.
  assign occ       = {1'b0, count} + (CNT_W+1)'(stage_valid[0]) + (CNT_W+1)'(stage_valid[1]);
  assign issue     = rst && grant_any && (occ < (CNT_W+1)'(OUT_DEPTH));
  assign req_ready = issue ? (NUM_REQ'(1) << grant_id) : '0;
  assign busy      = (occ != '0);

  always_comb begin
    sel_data = '0;
    sel_mode = ACT_RELU;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_mode = act_mode_e'(req_mode[2*i +: 2]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr <= '0;
    else if (issue) ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  end

  act_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .ID_W      (ID_W)
  ) u_act (
    .clk        (clk),
    .rst        (rst),
    .valid      (issue),
    .data       (sel_data),
    .mode       (sel_mode),
    .id         (grant_id),
    .stage_valid(stage_valid),
    .res_data   (res_data),
    .res_id     (res_id)
  );

  assign push = stage_valid[1];
  assign pop  = rsp_valid && rsp_ready;

  // NOTE: FIFO storage is not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{id: res_id, data: res_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign rsp_valid = (count != '0);
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_id    = rsp_valid ? head.id : '0;

endmodule

// File: tb/tb_act_sched.sv
// Self-checking bench for act_sched: directed scenario tasks plus an issue-order scoreboard.
module tb_act_sched;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int OD = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*DW-1:0] req_data;
  logic [2*NR-1:0]  req_mode;
  logic             rsp_valid, rsp_ready, busy;
  logic signed [DW-1:0] rsp_data;
  logic [1:0]       rsp_id;

  int checks  = 0;
  int fails   = 0;
  int max_out = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    id;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  act_sched #(.DATA_WIDTH(DW), .FRAC_BITS(4), .NUM_REQ(NR), .OUT_DEPTH(OD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .req_mode (req_mode),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_id   (rsp_id),
    .busy     (busy)
  );

  // Reference arithmetic on plain integers.
  function automatic logic [DW-1:0] model(input logic signed [DW-1:0] x, input logic [1:0] mode);
    int xi, r, q;
    xi = x;
    r  = xi + 48;
    if (r < 0)  r = 0;
    if (r > 96) r = 96;
    case (mode)
      2'd0: q = (xi < 0) ? 0 : xi;
      2'd1: begin
        q = (xi * r) / 96;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
      end
      2'd2:    q = r / 6;
      default: q = xi;
    endcase
    return 8'(q);
  endfunction

  // Scoreboard: push on each transfer, pop and compare on each accepted response.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got data=%0d id=%0d, required no response", rsp_data, rsp_id);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rsp_data !== e.data || rsp_id !== e.id) begin
            fails++;
            $display("FAIL sb_result: got data=%0d id=%0d, required data=%0d id=%0d",
                     rsp_data, rsp_id, $signed(e.data), e.id);
          end
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          e.data = model(req_data[i*DW +: DW], req_mode[2*i +: 2]);
          e.id   = 2'(i);
          sb.push_back(e);
        end
      end
      if (sb.size() > max_out) max_out = sb.size();
    end
  end

  task automatic set_req(input int i, input int x, input int mode);
    req_data[i*DW +: DW] = 8'(x);
    req_mode[2*i +: 2]   = 2'(mode);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic wait_idle();
    bit idle;
    idle      = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: busy=%b, required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 5, 3);
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    checks++; if (rsp_data !== 8'sd0) begin fails++; $display("FAIL reset_rsp_data: got %0d, required 0", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id: got %0d, required 0", rsp_id); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
  endtask

  task automatic test_latency();
    set_req(1, 16, 1);
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL lat_grant: got %b, required 0010", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL lat_k1: rsp_valid=%b, required 0", rsp_valid); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL lat_k2: rsp_valid=%b, required 0", rsp_valid); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'sd10 || rsp_id !== 2'd1) begin
      fails++;
      $display("FAIL lat_result: got valid=%b data=%0d id=%0d, required valid=1 data=10 id=1",
               rsp_valid, rsp_data, rsp_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue_one(input int id, input int x, input int mode, input int expv, input string name);
    bit got;
    got = 1'b0;
    set_req(id, x, mode);
    req_valid = 4'(1 << id);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1 req_valid = '0;
    if (got) begin
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (rsp_valid) begin
          got = 1'b1;
          break;
        end
      end
    end
    checks++;
    if (!got || rsp_data !== 8'(expv) || rsp_id !== 2'(id)) begin
      fails++;
      $display("FAIL %s: got valid=%b data=%0d id=%0d, required data=%0d id=%0d",
               name, rsp_valid, rsp_data, rsp_id, expv, id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mode_sweep();
    int xs[10]   = '{-16, -16, -16, -16, 48, 48, 48, -48, -48, -48};
    int ms[10]   = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 2};
    int exps[10] = '{0, -5, 5, -16, 48, 48, 16, 0, 0, 0};
    for (int i = 0; i < 10; i++) issue_one(i % NR, xs[i], ms[i], exps[i], $sformatf("sweep_%0d", i));
  endtask

  task automatic test_edges();
    int xs[4]   = '{127, -128, 8, -64};
    int exps[4] = '{127, 0, 4, 0};
    for (int i = 0; i < 4; i++) issue_one(3 - i, xs[i], 1, exps[i], $sformatf("hswish_edge_%0d", i));
  endtask

  task automatic test_round_robin();
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, $urandom_range(0, 255), $urandom_range(0, 3));
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(1 << (k % NR))) begin
        fails++;
        $display("FAIL rr_grant_%0d: got %b, required %b", k, req_ready, 4'(1 << (k % NR)));
      end
      if (k >= 3) begin
        checks++;
        if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rr_throughput_%0d: rsp_valid=%b, required 1", k, rsp_valid); end
      end
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) set_req(i, $urandom_range(0, 255), $urandom_range(0, 3));
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int n;
    logic [DW-1:0] held_d;
    logic [1:0]    held_id;
    n = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, $urandom_range(0, 255), $urandom_range(0, 3));
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready != '0) n++;
      @(posedge clk); #1;
    end
    checks++; if (n !== OD) begin fails++; $display("FAIL bp_transfers: got %0d, required %0d", n, OD); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready: got %b, required 0000", req_ready); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_busy: got %b, required 1", busy); end
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_rsp_valid: got %b, required 1", rsp_valid); end
    held_d  = rsp_data;
    held_id = rsp_id;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_data !== held_d || rsp_id !== held_id) begin
      fails++;
      $display("FAIL bp_hold: got data=%0d id=%0d, required data=%0d id=%0d", rsp_data, rsp_id, $signed(held_d), held_id);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_credit_late: got %b, required 0000", req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (req_ready === 4'b0000) begin fails++; $display("FAIL bp_resume: got %b, required a grant", req_ready); end
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1;
    wait_idle();
  endtask

  task automatic test_reset_midstream();
    int n, seen;
    n = 0;
    seen = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 16 * i + 1, 3);
    req_valid = '1;
    for (int c = 0; c < 10 && n < 3; c++) begin
      @(negedge clk);
      if (req_ready != '0) n++;
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_ready_in_reset: got %b, required 0000", req_ready); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_rsp_valid: got %b, required 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b, required 0", busy); end
    checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_ptr_restart: got %b, required 0001", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++; if (seen !== 1) begin fails++; $display("FAIL mid_stale: got %0d responses, required 1", seen); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_mode  = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_latency();
    test_mode_sweep();
    test_edges();
    test_round_robin();
    test_backpressure();
    test_reset_midstream();
    wait_idle();
    checks++;
    if (max_out > OD) begin fails++; $display("FAIL overflow: outstanding reached %0d, limit %0d", max_out, OD); end
    checks++;
    if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover: %0d results never returned, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/act_sched.md
# act_sched

Round-robin scheduler that shares one activation unit (ReLU / hswish / hsigmoid / bypass) among several requesters. It sits between the conv/depthwise engines and the single activation datapath. It accepts tagged Q4.4 operands over valid/ready, issues one per cycle into a fixed-latency pipeline and buffers results in an output FIFO. Issue is credit-gated, so results are never dropped under output backpressure.

## Interface
- DATA_WIDTH, 8, operand/result width, signed fixed point
- FRAC_BITS, 4, fractional bits (Q4.4)
- NUM_REQ, 4, number of requesters (≥2)
- OUT_DEPTH, 4, output FIFO depth and total credit count (≥3)

- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
- req_data  in  NUM_REQ×DATA_WIDTH  per-requester signed operand
- req_mode  in  NUM_REQ×2  per-requester mode: 00 ReLU, 01 hswish, 10 hsigmoid, 11 bypass
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  DATA_WIDTH  signed result
- rsp_id  out  $clog2(NUM_REQ)  index of the originating requester
- busy  out  1  high when occupancy is not 0

## Operation
- occupancy = (valid pipeline stages) + fifo_count. Both terms are registered values.
- Issue is allowed when occupancy < OUT_DEPTH. A pop in the same cycle does not free a credit until the next cycle.
- Arbitration:
  - Search starts at pointer `ptr` and proceeds upward with wrap.
  - The first valid requester gets req_ready, combinationally from req_valid and registered state.
  - req_ready is all zeros if issue is not allowed or rst is low.
  - Requesters must not make req_valid depend on req_ready.
- Transfer occurs when req_valid[i] and req_ready[i] are both high. On a transfer, ptr ← i+1 modulo NUM_REQ; otherwise ptr holds.
- Arithmetic, all on raw integers:
  - r = clamp(x+48, 0, 96). This is relu6(x+3) in Q4.4.
  - ReLU = max(x, 0).
  - hswish = sat8(trunc0(x·r / 96)). The product is 15-bit signed.
  - hsigmoid = trunc0(r / 6). Range is 0..16.
  - bypass = x.
  - trunc0 truncates toward zero; sat8 clamps to [-128, 127].
- Ordering: results leave in issue order, tagged with the requester index.
- FIFO write on pipeline exit. Pop when rsp_valid and rsp_ready are both high. Write and pop in the same cycle are allowed, including when the FIFO is full-1 or empty-with-bypass-prohibited.
- Overflow cannot occur because of the credit rule; the bench asserts this.

## Timing
- A request accepted at edge k is written to the FIFO at edge k+2. rsp_valid is high in the cycle after edge k+2.
- Minimum latency is 2 cycles. There is no combinational path from req_* to rsp_*.
- With rsp_ready held high, throughput is one result per cycle and occupancy never exceeds 3.
- With rsp_ready low, exactly OUT_DEPTH requests are accepted, then req_ready stays 0 until a pop has been registered.
- rsp_data and rsp_id hold stable while rsp_valid is high and rsp_ready is low.
- Reset, with rst low at an edge:
  - ptr = 0, pipeline valids = 0, FIFO empty.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0, req_ready = 0.
  - Reset mid-stream discards in-flight and buffered results. The first request after rst rises is accepted at the first edge with rst high.

## Structure
- Package act_pkg holds:
  - mode enum act_mode_e (ACT_RELU, ACT_HSWISH, ACT_HSIGMOID, ACT_BYPASS)
  - constants RELU6_OFFSET = 48, RELU6_MAX = 96, HSWISH_DIV = 96, HSIG_DIV = 6
- Sub-module act_unit is the 2-stage pipeline:
  - Inputs: data, mode, id, valid.
  - Stage 1 computes r and the product.
  - Stage 2 performs the divide/saturate and the mode mux.
  - The id and valid tag travel alongside the data.
- act_sched contains the arbiter, the credit logic and the FIFO.

## Test plan
- Single requester 1, hswish, x=16, rsp_ready=1 → rsp_data=10, rsp_id=1, rsp_valid in the cycle after edge k+2.
- Mode sweep:
  - x=-16 → ReLU 0, hswish -5, hsigmoid 5, bypass -16.
  - x=48 → ReLU 48, hswish 48, hsigmoid 16.
  - x=-48 → all of ReLU, hswish and hsigmoid give 0.
- Edges, hswish:
  - x=127 → 127
  - x=-128 → 0
  - x=8 → 4
  - x=-64 → 0
- All 4 requesters valid continuously with rsp_ready=1 → grants 0,1,2,3,0,… with one per cycle, and rsp_id follows the same order.
- rsp_ready=0 with all requesters valid → 4 transfers, then req_ready=0, busy=1. Raising rsp_ready drains 4 results in order, then issuing resumes.
- rst low for 1 cycle with 3 results outstanding → rsp_valid=0 next cycle, no stale results appear afterward, and ptr restarts at requester 0.
